// File: rtl/aes_key_mem.sv
// AES round-key generator and store: expands a 128/256-bit cipher key into
// 11 or 15 round keys, one per cycle, and serves them by round index.
module aes_key_mem (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         keylen,
    input  logic [255:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready
);

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b sits at bits (255-b)*8 +: 8, and (255-b) == ~b for an 8-bit b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            keylen_q, keylen_d;
    logic            ready_q, ready_d;
    logic [1919:0]   rk_flat;
    logic [3:0]      last_idx;
    logic            odd_step;
    logic [127:0]    prev_key, base_key, next_key;
    logic [31:0]     temp_word, w0, w1, w2, w3;

    assign last_idx = keylen_q ? 4'd14 : 4'd10;
    // AES-256 odd steps use SubWord only; Rcon is neither applied nor advanced.
    assign odd_step = keylen_q & idx_q[0];

    assign prev_key  = rk_flat[{idx_q - 4'd1, 7'b0} +: 128];
    assign base_key  = keylen_q ? rk_flat[{idx_q - 4'd2, 7'b0} +: 128] : prev_key;
    assign temp_word = odd_step ? sub_word(prev_key[31:0])
                                : sub_word({prev_key[23:0], prev_key[31:24]}) ^ {rcon_q, 24'h0};

    assign w0 = base_key[127:96] ^ temp_word;
    assign w1 = base_key[95:64]  ^ w0;
    assign w2 = base_key[63:32]  ^ w1;
    assign w3 = base_key[31:0]   ^ w2;
    assign next_key = {w0, w1, w2, w3};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rcon_d   = rcon_q;
        keylen_d = keylen_q;
        ready_d  = ready_q;
        case (state_q)
            GEN: begin
                if (idx_q == last_idx) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
                if (!odd_step) begin
                    rcon_d = xtime(rcon_q);
                end
            end
            default: ;
        endcase
        // A fresh init restarts from any state.
        if (init) begin
            state_d  = GEN;
            keylen_d = keylen;
            idx_d    = keylen ? 4'd2 : 4'd1;
            rcon_d   = 8'h01;
            ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            rcon_q   <= 8'h01;
            keylen_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rcon_q   <= rcon_d;
            keylen_q <= keylen_d;
            ready_q  <= ready_d;
        end
    end

    for (genvar gi = 0; gi < 15; gi++) begin : g_rk
        localparam logic [3:0] IDX = 4'(gi);
        logic         we;
        logic [127:0] wdata;
        logic [127:0] rk_q;

        if (gi == 0) begin : g_first
            assign we    = init;
            assign wdata = key[255:128];
        end else if (gi == 1) begin : g_second
            assign we    = init ? keylen : (state_q == GEN && idx_q == IDX);
            assign wdata = init ? key[127:0] : next_key;
        end else begin : g_rest
            assign we    = !init && state_q == GEN && idx_q == IDX;
            assign wdata = next_key;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rk_q <= '0;
            end else if (we) begin
                rk_q <= wdata;
            end
        end

        assign rk_flat[gi*128 +: 128] = rk_q;
    end

    assign round_key = (round > last_idx) ? 128'h0 : rk_flat[{round, 7'b0} +: 128];
    assign ready     = ready_q;

endmodule
